// File: rtl/fifo_uart_tx_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: FSM encoding, line levels,
// and the baud-counter width helper. Build option: FIFO_UART_TX_PARITY_EN.
package fifo_uart_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_POP    = 3'd1,
    ST_WAIT   = 3'd2,
    ST_START  = 3'd3,
    ST_DATA   = 3'd4,
    ST_STOP   = 3'd5,
    ST_PARITY = 3'd6
  } state_t;

  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;

  // Baud counter width: log2(clks_per_bit)+1 bits
  function automatic int calc_cnt_width(input int clks_per_bit);
    return $clog2(clks_per_bit) + 1;
  endfunction

endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO read-port and UART line bundle between the FIFO side and the transmitter.
// master = transmitter side, slave = FIFO/pin side.
interface fifo_uart_tx_if #(
  parameter int data_width = 8
);
  logic                  fifo_empty;
  logic [data_width-1:0] fifo_dout;
  logic                  fifo_rd_en;
  logic                  tx;
  logic                  busy;

  modport master (
    input  fifo_empty, fifo_dout,
    output fifo_rd_en, tx, busy
  );

  modport slave (
    output fifo_empty, fifo_dout,
    input  fifo_rd_en, tx, busy
  );
endinterface

// File: rtl/fifo_uart_tx_baud_tick.sv
// Bit-period timer: counts 0..clks_per_bit-1 and pulses tick on the last count.
// Shared with the matching UART receiver.
module uart_baud_tick
  import fifo_uart_tx_pkg::*;
#(
  parameter int clks_per_bit = 10,
  parameter int cnt_width    = calc_cnt_width(clks_per_bit)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);
  localparam logic [cnt_width-1:0] CNT_LAST = cnt_width'(clks_per_bit - 1);

  logic [cnt_width-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_reg <= '0;
    end else if (cnt_reg == CNT_LAST) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign tick = (cnt_reg == CNT_LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from the async FIFO read port and sends each as an 8N1 UART frame, LSB first.
// Define FIFO_UART_TX_PARITY_EN to add an even-parity bit (8E1).
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int data_width   = 8,
  parameter int clk_freq     = 50000000,
  parameter int baud_rate    = 115200,
  parameter int clks_per_bit = clk_freq / baud_rate,
  parameter int cnt_width    = calc_cnt_width(clks_per_bit)
) (
  input  logic             clk,
  input  logic             rst,
  fifo_uart_tx_if.master   bus
);
  localparam int IDX_W = (data_width > 1) ? $clog2(data_width) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(data_width - 1);

  state_t                state_reg, state_next;
  logic [data_width-1:0] shift_reg, shift_next;
  logic [IDX_W-1:0]      idx_reg, idx_next;
  logic                  tx_reg, tx_next;
  logic                  rd_en_reg;
  logic                  busy_reg;
  logic                  baud_clear;
  logic                  baud_tick;
`ifdef FIFO_UART_TX_PARITY_EN
  logic                  parity_reg, parity_next;
`endif

  uart_baud_tick #(
    .clks_per_bit (clks_per_bit),
    .cnt_width    (cnt_width)
  ) u_baud (
    .clk   (clk),
    .rst   (rst),
    .clear (baud_clear),
    .tick  (baud_tick)
  );

  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    idx_next   = idx_reg;
    baud_clear = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
    parity_next = parity_reg;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (!bus.fifo_empty) state_next = ST_POP;
      end
      ST_POP: state_next = ST_WAIT;
      ST_WAIT: begin
        shift_next = bus.fifo_dout;
        baud_clear = 1'b1;
        state_next = ST_START;
`ifdef FIFO_UART_TX_PARITY_EN
        parity_next = ^bus.fifo_dout;
`endif
      end
      ST_START: begin
        if (baud_tick) begin
          state_next = ST_DATA;
          idx_next   = '0;
        end
      end
      ST_DATA: begin
        if (baud_tick) begin
          shift_next = shift_reg >> 1;
          if (idx_reg == IDX_LAST) begin
`ifdef FIFO_UART_TX_PARITY_EN
            state_next = ST_PARITY;
`else
            state_next = ST_STOP;
`endif
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      ST_PARITY: begin
        if (baud_tick) state_next = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (baud_tick) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase

    // Line level is computed from the upcoming state so tx stays a registered output
    tx_next = UART_IDLE_LEVEL;
    case (state_next)
      ST_START:  tx_next = UART_START_LEVEL;
      ST_DATA:   tx_next = shift_next[0];
`ifdef FIFO_UART_TX_PARITY_EN
      ST_PARITY: tx_next = parity_next;
`endif
      default:   tx_next = UART_IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      shift_reg <= '0;
      idx_reg   <= '0;
      tx_reg    <= UART_IDLE_LEVEL;
      rd_en_reg <= 1'b0;
      busy_reg  <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_reg <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      shift_reg <= shift_next;
      idx_reg   <= idx_next;
      tx_reg    <= tx_next;
      rd_en_reg <= (state_next == ST_POP);
      busy_reg  <= (state_next != ST_IDLE);
`ifdef FIFO_UART_TX_PARITY_EN
      parity_reg <= parity_next;
`endif
    end
  end

  assign bus.tx         = tx_reg;
  assign bus.fifo_rd_en = rd_en_reg;
  assign bus.busy       = busy_reg;

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Read-side consumer for the team's async FIFO. Pops bytes one at a time and serialises each as an asynchronous UART frame (8N1 by default, LSB first) on `tx`.
- Sits in the `rd_clk` domain of the FIFO, between the FIFO read port and the board TX pin.
- The FIFO pops only on a rising edge of its `rd_en`, so this block always drives `fifo_rd_en` as a single-cycle pulse.

Parameters:
- data_width, 8, bits per UART data field and FIFO word width.
- clk_freq, 50000000, clk frequency in Hz.
- baud_rate, 115200, line rate in bits/s.
- clks_per_bit, clk_freq/baud_rate (integer division, truncating), clk cycles per UART bit. Must be >= 2.
- cnt_width, `log2(clks_per_bit)+1`, width of the baud counter.

Ports:
- clk  input  1  block clock; same clock as the FIFO rd_clk.
- rst  input  1  synchronous, active-high reset.
- fifo_empty  input  1  FIFO empty flag.
- fifo_dout  input  data_width  FIFO read data; valid the cycle after a fifo_rd_en pulse.
- fifo_rd_en  output  1  pop request; one-cycle pulse only.
- tx  output  1  UART serial line; idle high.
- busy  output  1  high from POP through the end of the stop bit.

Behaviour:
- Reset: synchronous, active-high; sampled on posedge clk. The next cycle gives state=IDLE, tx=1, fifo_rd_en=0, busy=0, baud counter=0, bit index=0, shift register=0.
- States: IDLE, POP, WAIT, START, DATA, (PARITY), STOP.
- IDLE:
  - tx=1, busy=0.
  - If !fifo_empty, go to POP; otherwise stay in IDLE.
- POP:
  - fifo_rd_en=1 for exactly this one cycle; busy=1.
  - Unconditionally go to WAIT.
- WAIT:
  - fifo_rd_en=0. fifo_dout is valid this cycle.
  - Capture fifo_dout into the shift register at the end of this cycle.
  - Clear the baud counter and go to START.
- START: tx=0 for clks_per_bit cycles, then go to DATA with bit index=0.
- DATA:
  - tx=shift[0] for clks_per_bit cycles.
  - Then shift right. If bit index==data_width-1, leave DATA (to PARITY if enabled, else STOP); otherwise increment the index.
- STOP: tx=1 for clks_per_bit cycles, then return to IDLE.
- Baud counter:
  - Counts 0..clks_per_bit-1 and wraps to 0; each wrap ends one bit period.
  - No fractional-baud accumulation; the truncation error is accepted.
- fifo_rd_en is never high on two consecutive cycles, and is low for at least one full frame between pulses. This guarantees the FIFO sees a rising edge on every pop.
- Pop guard: fifo_rd_en is never asserted while fifo_empty=1. fifo_empty is sampled only in IDLE; changes during a frame are ignored.
- Latency:
  - From IDLE with fifo_empty falling, the start bit begins (tx falls) 3 cycles after the first cycle fifo_empty is seen low: IDLE→POP→WAIT→START.
  - Back-to-back frames: inter-frame gap = stop bit + 3 cycles of idle-high (IDLE, POP, WAIT) before the next start bit.
- Reset mid-frame: the frame is aborted and tx returns to 1 the next cycle. A byte already popped is lost; there is no re-read.
- tx and fifo_rd_en are registered outputs (no combinational path from inputs).

Optional Feature:
- Macro: FIFO_UART_TX_PARITY_EN
- Defined:
  - PARITY state inserted between DATA and STOP.
  - tx = XOR-reduction of the captured byte (even parity) for clks_per_bit cycles.
  - Frame becomes 8E1 (data_width+3 bit times).
- Undefined: no PARITY state and no parity logic; frame is 8N1 (data_width+2 bit times).

Decomposition:
- Shared header alongside util.vh:
  - state encoding localparams (IDLE=0 … STOP, PARITY).
  - UART_IDLE_LEVEL=1.
  - UART_START_LEVEL=0.
  - Uses `log2 from util.vh for cnt_width.
- One sub-module, uart_baud_tick:
  - Parameters: clks_per_bit.
  - Inputs: clk, rst, clear. Output: tick (one-cycle pulse per bit period).
  - Reused later by the matching receiver.

Test Plan (clk_freq=1000, baud_rate=100 → clks_per_bit=10; FIFO model behaves like the team's async FIFO):
- Reset with FIFO empty → tx=1, busy=0, fifo_rd_en=0 for 100 cycles.
- Push 0xA5 → exactly one fifo_rd_en pulse; tx falls 3 cycles after fifo_empty falls; line bits are 0,1,0,1,0,0,1,0,1,1, each 10 cycles wide (start, 0xA5 LSB-first, stop); busy falls after the 100th frame cycle.
- Push 0x00, 0xFF, 0x3C together → three frames in order; every fifo_rd_en pulse is 1 cycle wide with ≥100 low cycles between pulses; gap between stop-bit end and next start = 3 cycles; FIFO ends empty; no pop while empty.
- Assert rst during bit 4 of 0x5A → tx=1 the next cycle, state IDLE; a subsequently pushed 0x81 transmits correctly.
- With FIFO_UART_TX_PARITY_EN: 0x07 → parity bit 1; 0x03 → parity bit 0; frame is 110 cycles.
- Hold fifo_empty=1 while toggling fifo_dout randomly → fifo_rd_en is never asserted and tx stays 1.
